// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and FSM state encoding for the LEGv8 instruction-fetch block.
package fetch_pkg;

   localparam int ADDR_W     = 32;
   localparam int ROM_DATA_W = 64;
   localparam int INSTR_W    = 32;

   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ADDR   = 2'd0,
      READ   = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-ROM bus and the decode handshake/redirect signals of the fetch unit.
interface instr_fetch_if;
   import fetch_pkg::*;

   logic [ADDR_W-1:0]     rom_address;
   logic                  rom_chip_select;
   logic                  rom_output_enable;
   logic [ROM_DATA_W-1:0] rom_data;
   logic [INSTR_W-1:0]    instr;
   logic [ADDR_W-1:0]     instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  redirect;
   logic [ADDR_W-1:0]     redirect_target;

   // master is the fetch unit; slave is the ROM/decode/execute side around it
   modport master (
      output rom_address, rom_chip_select, rom_output_enable,
      output instr, instr_pc, instr_valid,
      input  rom_data, instr_ready, redirect, redirect_target
   );

   modport slave (
      input  rom_address, rom_chip_select, rom_output_enable,
      input  instr, instr_pc, instr_valid,
      output rom_data, instr_ready, redirect, redirect_target
   );

endinterface

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter: counts the output-enable cycles of a ROM read and flags the last one.
module fetch_wait_counter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic terminal_o
);

   localparam int                CNT_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign terminal_o = (count_q == LAST);

   // Wrap to zero after the last count so back-to-back reads start clean
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = terminal_o ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: LEGv8 instruction-fetch bus master; owns the PC, drives the ROM and hands words to decode.
// Optional FETCH_HALT_ON_ZERO_EN: a captured all-zero ROM word parks the fetcher in HALTED.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
   parameter int                WAIT_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   instr_fetch_if.master bus
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  instrPc_q;
   logic               cs_q, cs_d;
   logic               oe_q, oe_d;
   logic               waitDone;
   logic               countClear;
   logic               countEnable;
   logic               captureInstr;
   logic               captureFault;
   logic [ADDR_W-1:0]  redirectPc;
   logic               unusedTargetLsb;

   assign redirectPc      = {bus.redirect_target[ADDR_W-1:2], 2'b00};
   assign unusedTargetLsb = ^bus.redirect_target[1:0];
   assign countEnable     = (state_q == READ);
   assign countClear      = bus.redirect || (state_q != READ);

   fetch_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) waitCounter (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_i   (countClear),
      .enable_i  (countEnable),
      .terminal_o(waitDone)
   );

`ifdef FETCH_HALT_ON_ZERO_EN
   logic romWordZero;
   assign romWordZero = (bus.rom_data == '0);
`else
   logic unusedRomHi;
   assign unusedRomHi = ^bus.rom_data[ROM_DATA_W-1:INSTR_W];
`endif

   // Redirect is applied last so it overrides both capture and the decode handshake
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      captureInstr = 1'b0;
      captureFault = 1'b0;
      case (state_q)
         ADDR: state_d = READ;
         READ: begin
            if (waitDone) begin
`ifdef FETCH_HALT_ON_ZERO_EN
               if (romWordZero) begin
                  state_d      = HALTED;
                  captureFault = 1'b1;
               end else begin
                  state_d      = HOLD;
                  captureInstr = 1'b1;
               end
`else
               state_d      = HOLD;
               captureInstr = 1'b1;
`endif
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               state_d = ADDR;
               pc_d    = pc_q + PC_STEP;
            end
         end
`ifdef FETCH_HALT_ON_ZERO_EN
         HALTED: state_d = HALTED;
`endif
         default: state_d = ADDR;
      endcase
      if (bus.redirect) begin
         state_d      = ADDR;
         pc_d         = redirectPc;
         captureInstr = 1'b0;
         captureFault = 1'b0;
      end
      cs_d = (state_d == ADDR) || (state_d == READ);
      oe_d = (state_d == READ);
   end

   // ROM strobes are registered from the next state so they stay glitch-free and are low in reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ADDR;
         pc_q      <= RESET_PC;
         cs_q      <= 1'b0;
         oe_q      <= 1'b0;
         instr_q   <= '0;
         instrPc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cs_q    <= cs_d;
         oe_q    <= oe_d;
         if (captureInstr) begin
            instr_q   <= bus.rom_data[INSTR_W-1:0];
            instrPc_q <= pc_q;
         end else if (captureFault) begin
            instrPc_q <= pc_q;
         end
      end
   end

   assign bus.rom_address       = pc_q;
   assign bus.rom_chip_select   = cs_q;
   assign bus.rom_output_enable = oe_q;
   assign bus.instr             = instr_q;
   assign bus.instr_pc          = instrPc_q;
   assign bus.instr_valid       = (state_q == HOLD);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch initiator for the LEGv8 datapath: the bus-master end of the instruction-ROM interface. It owns the program counter and drives the ROM's address, chip-select and output-enable. After a configurable access delay it captures the 64-bit ROM word and presents the low 32 bits to decode through a valid/ready handshake. Branch redirects from execute override any fetch in flight.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- WAIT_CYCLES, 1, cycles output-enable is held before `rom_data` is sampled; legal range ≥1
- clock  input  1  system clock, rising-edge
- reset_n  input  1  reset; asynchronous, active-low
- rom_address  output  32  byte address to ROM; equals PC
- rom_chip_select  output  1  ROM select
- rom_output_enable  output  1  ROM output drive enable
- rom_data  input  64  ROM data bus
- instr  output  32  captured instruction, `rom_data[31:0]`
- instr_pc  output  32  address `instr` was fetched from
- instr_valid  output  1  `instr` / `instr_pc` valid
- instr_ready  input  1  decode accepts the instruction
- redirect  input  1  load new PC and abandon the current fetch
- redirect_target  input  32  new PC; bits [1:0] forced to 0

## Operation
- States:
  - ADDR: cs=1, oe=0.
  - READ: cs=1, oe=1; wait counter runs.
  - HOLD: cs=0, oe=0, instr_valid=1.
  - HALTED: only when the config macro is defined.
- Transitions:
  - ADDR→READ unconditionally.
  - READ: counter counts 0..WAIT_CYCLES-1. On the last count, capture `rom_data` into `instr` / `instr_pc`, then go to HOLD.
  - HOLD→ADDR on instr_valid & instr_ready. PC += 4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Redirect, any state: PC ← {redirect_target[31:2],2'b00}. instr_valid drops next cycle, counter clears, state ← ADDR.
- Redirect and handshake in the same cycle: redirect wins. The held instruction counts as consumed, and the PC is not incremented.
- `rom_address` holds the PC stable for all of ADDR and READ. It changes only on a state entry into ADDR.
- `instr` and `instr_pc` hold their value outside capture, including while instr_valid=0.
- `rom_data[63:32]` is ignored, except by the halt check.

## Timing
- Reset values:
  - state=ADDR, PC=RESET_PC
  - rom_address=RESET_PC, rom_chip_select=0, rom_output_enable=0
  - instr=0, instr_pc=0, instr_valid=0
- ROM outputs are registered from state: cs rises 1 cycle after reset release.
- Latency from entering ADDR to instr_valid=1 is WAIT_CYCLES+1 edges. With WAIT_CYCLES=1, valid appears on the 2nd edge after ADDR entry.
- Peak throughput: one instruction per WAIT_CYCLES+2 cycles, with instr_ready held high.
- Reset asserted mid-fetch aborts immediately; no partial capture.
- instr_valid never depends combinationally on instr_ready.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined:
  - A captured `rom_data` of 64'h0 (the unmapped-address word) enters HALTED instead of HOLD.
  - In HALTED: instr_valid=0, cs=0, oe=0, `instr_pc` is updated to the faulting PC.
  - Only redirect or reset leaves HALTED.
- Undefined:
  - The zero word is delivered as a normal instruction with instr=0.
  - HALTED does not exist.

## Structure
- Package `fetch_pkg`:
  - state enum (ADDR, READ, HOLD, HALTED)
  - ADDR_W=32, ROM_DATA_W=64, INSTR_W=32, PC_STEP=4
- Sub-module `fetch_wait_counter`: clear, enable, terminal-count output, width $clog2(WAIT_CYCLES+1).

## Test plan
- Reset release, RESET_PC=0, WAIT_CYCLES=1, ROM word at 0 = ADDI encoding, ready=1 → instr_valid on 2nd edge; instr=32'h912AABE0, instr_pc=0; next rom_address=4.
- ready=0 for 5 cycles in HOLD → instr and instr_pc stable, cs=oe=0, PC unchanged; ready=1 → advance to PC=4.
- redirect=1, target=32'h0000001E, asserted during READ → instr_valid stays 0; next ADDR drives 32'h0000001C.
- redirect and handshake in the same cycle, target=32'h40 → rom_address=32'h40, not PC+4.
- RESET_PC=32'hFFFFFFFC, handshake → rom_address wraps to 0.
- With FETCH_HALT_ON_ZERO_EN, fetch from 32'h0C returning 64'h0 → HALTED, instr_valid=0, instr_pc=32'h0C; redirect to 0 → fetch resumes. Without the macro → instr=0 delivered with valid=1.
